// File: rtl/sprinkler_zone_sequencer.sv
// rtl/sprinkler_zone_sequencer.sv - timed zone sequencer with break-before-make and manual select
// Steps through enabled zones one valve at a time; all outputs are registered.
module sprinkler_zone_sequencer #(
  parameter int NUM_ZONES = 4,
  parameter int SEL_W     = 2,
  parameter int DUR_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 manual,
  input  logic [SEL_W-1:0]     man_sel,
  input  logic [NUM_ZONES-1:0] zone_enable,
  input  logic [DUR_W-1:0]     duration,
  input  logic                 tick,
  output logic [NUM_ZONES-1:0] valve,
  output logic [SEL_W-1:0]     active_zone,
  output logic                 busy,
  output logic                 done
);

  localparam int NSEL = 1 << SEL_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_WATER,
    S_GAP,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [SEL_W:0]         idx_q, idx_d;
  logic [DUR_W-1:0]       timer_q, timer_d;
  logic [NUM_ZONES-1:0]   valve_q, valve_d;
  logic [SEL_W-1:0]       active_q, active_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Padding lets any SEL_W-bit index address the enable vector safely.
  logic [NSEL-1:0]        en_pad;
  logic                   man_ok;
  logic                   scan_end;

  assign en_pad   = NSEL'(zone_enable);
  assign man_ok   = ({1'b0, man_sel} < (SEL_W+1)'(NUM_ZONES)) && en_pad[man_sel];
  assign scan_end = (idx_q == (SEL_W+1)'(NUM_ZONES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      timer_q  <= '0;
      valve_q  <= '0;
      active_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      valve_q  <= valve_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    valve_d  = valve_q;
    active_d = active_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    if (state_q != S_IDLE && abort) begin
      state_d  = S_IDLE;
      idx_d    = '0;
      timer_d  = '0;
      valve_d  = '0;
      active_d = '0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          valve_d  = '0;
          active_d = '0;
          if (!abort) begin
            if (manual) begin
              if (man_ok) begin
                valve_d  = NUM_ZONES'(1) << man_sel;
                active_d = man_sel;
              end
            end else if (start) begin
              idx_d   = '0;
              busy_d  = 1'b1;
              state_d = S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (scan_end) begin
            state_d = S_DONE;
          end else if (en_pad[idx_q[SEL_W-1:0]] && duration != '0) begin
            timer_d  = duration;
            valve_d  = NUM_ZONES'(1) << idx_q[SEL_W-1:0];
            active_d = idx_q[SEL_W-1:0];
            state_d  = S_WATER;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        S_WATER: begin
          if (tick) begin
            if (timer_q == DUR_W'(1)) begin
              timer_d  = '0;
              valve_d  = '0;
              active_d = '0;
              idx_d    = idx_q + 1'b1;
              state_d  = S_GAP;
            end else begin
              timer_d = timer_q - DUR_W'(1);
            end
          end
        end
        S_GAP: begin
          state_d = S_SCAN;
        end
        S_DONE: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          idx_d   = '0;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign valve       = valve_q;
  assign active_zone = active_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/sprinkler_zone_sequencer.md
Name: sprinkler_zone_sequencer

Overview:
- Timed, parametrised successor to the 4-input valve select mux. Generalised to NUM_ZONES zones.
- Automatically steps through enabled zones, opening one valve at a time for a programmed number of time-base ticks.
- Enforces a break-before-make gap between zones.
- Provides a manual mode: a registered N:1 one-hot select with enable gating.
- Sits between the front-panel switch logic and the valve drivers of the sprinkler valve controller.

Parameters:
- NUM_ZONES, 4, number of valves/zones (2..16).
- SEL_W, 2, width of zone index; must satisfy 2**SEL_W >= NUM_ZONES.
- DUR_W, 8, width of the watering-duration counter in ticks.

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, level sampled each clock; starts an automatic cycle from IDLE.
- abort, input, 1, stops any cycle immediately.
- manual, input, 1, manual mode select (honoured in IDLE only).
- man_sel, input, SEL_W, zone index to open in manual mode.
- zone_enable, input, NUM_ZONES, per-zone enable; bit i = zone i participates.
- duration, input, DUR_W, ticks per zone; sampled when a zone is loaded.
- tick, input, 1, one-cycle time-base strobe, e.g. 1 Hz from a prescaler.
- valve, output, NUM_ZONES, registered one-hot or all-zero valve drive.
- active_zone, output, SEL_W, index of the zone currently watering; 0 when none.
- busy, output, 1, high while an automatic cycle is in progress.
- done, output, 1, one-cycle pulse when an automatic cycle completes normally.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, idx=0, timer=0, valve=0, active_zone=0, busy=0, done=0.
- States: IDLE, SCAN, WATER, GAP, DONE. All outputs are registered.
- IDLE
  - manual=1: next-cycle valve=onehot(man_sel) if man_sel<NUM_ZONES and zone_enable[man_sel]=1, else 0. active_zone=man_sel when a valve is open. start is ignored.
  - manual=0: valve=0.
  - start=1 and manual=0: idx<=0, go to SCAN, busy<=1. Manual valves close on the same edge.
- SCAN (one zone examined per cycle)
  - idx==NUM_ZONES: go to DONE.
  - zone_enable[idx]=1 and duration!=0: timer<=duration, valve<=onehot(idx), active_zone<=idx, go to WATER.
  - Otherwise (disabled zone, or duration==0): idx<=idx+1, stay in SCAN.
- WATER: the valve stays open; timer decrements only on cycles with tick=1. A tick with timer==1 sets timer<=0, valve<=0, active_zone<=0, idx<=idx+1, and goes to GAP.
- GAP: exactly one cycle with all valves off, then SCAN. No two valves are ever high in the same or adjacent cycles.
- DONE: done<=1 for one cycle, busy<=0, then IDLE. start held high re-triggers only after returning to IDLE.
- abort=1 in SCAN/WATER/GAP/DONE: next edge valve=0, active_zone=0, busy=0, idx=0, state=IDLE, no done pulse.
  - abort has priority over tick, start and timer expiry.
  - In IDLE, abort forces valve=0 for that cycle, manual included.
- Changes to zone_enable or duration during WATER do not affect the open zone. They apply when later zones are scanned.
- idx arithmetic is SEL_W+1 bits wide so that idx==NUM_ZONES is representable when NUM_ZONES==2**SEL_W.
- No latching of tick: a tick arriving in SCAN/GAP/DONE is dropped.
- Invariant: popcount(valve) <= 1 at all times.

Test Plan:
- Reset mid-WATER (rst_n low asynchronously with zone 2 open) -> valve=0, busy=0 immediately, without a clock edge; state IDLE after release.
- NUM_ZONES=4, zone_enable=4'b1111, duration=3, start pulse, tick every 4 clocks -> valve 0001, 0010, 0100, 1000 in turn, each open for exactly 3 ticks. All-zero GAP cycle between zones. done pulse once; busy falls with done.
- zone_enable=4'b1010, duration=2 -> only zones 1 and 3 open; scan skips zones 0 and 2 at one cycle each. duration=0 with all enabled -> no valve ever opens, done after 5 SCAN cycles.
- Abort asserted in WATER on zone 1, on a cycle with tick=1 and timer=1 -> next edge valve=0, IDLE, no done. A subsequent start begins at zone 0.
- manual=1, man_sel=2, zone_enable=4'b0100 -> valve=0100 one cycle later. man_sel=1 (disabled) -> valve=0. start=1 with manual=1 -> busy stays 0.
- Assertion across all tests: popcount(valve)<=1 every cycle; valve changes only on clk edges or rst_n assertion.
